// File: rtl/ram32_port_arbiter_pkg.sv
// Shared constants and FSM state encoding for the RAM32 port arbiter.
package ram32_ctrl_pkg;

  localparam int unsigned RAM_WORDS = 32;
  localparam int unsigned RAM_AW    = 5;
  localparam int unsigned RAM_LANES = 4;
  localparam int unsigned BYTE_AW   = 7;

  typedef enum logic [1:0] {
    ST_RST,
    ST_INIT,
    ST_RUN
  } state_t;

endpackage

// File: rtl/ram32_port_arbiter_if.sv
// Requester-side handshake bundle: master = requesters, slave = arbiter.
interface ram32_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  import ram32_ctrl_pkg::*;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         req_we;
  logic [BYTE_AW*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0]       req_wdata;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [7:0]                 rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/ram32_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the pointer with wrap.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'((32'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/ram32_port_arbiter.sv
// Shares the single-port RAM32 macro among byte-wide requesters with an
// optional post-reset zero-fill.
module ram32_port_arbiter
  import ram32_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ram32_port_arbiter_if.slave    req_bus,
  output logic                   init_done,
  output logic                   ram_en,
  output logic [RAM_AW-1:0]      ram_a,
  output logic [RAM_LANES-1:0]   ram_we,
  output logic [31:0]            ram_di,
  input  logic [31:0]            ram_do
);

  state_t              state;
  state_t              state_nxt;
  logic [RAM_AW-1:0]   clr_cnt;

  logic [NUM_REQ-1:0]  arb_req;
  logic [NUM_REQ-1:0]  grant;
  logic                granted;

  logic [BYTE_AW-1:0]  sel_addr;
  logic [7:0]          sel_wdata;
  logic                sel_we;
  logic [1:0]          sel_lane;

  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [1:0]          rsp_lane_q;
  logic                rsp_read_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RST;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST:  state_nxt = CLEAR_ON_RESET ? ST_INIT : ST_RUN;
      ST_INIT: if (clr_cnt == RAM_AW'(RAM_WORDS - 1)) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_RST;
    endcase
  end

  // Clear counter wraps back to 0 as INIT completes, so it rests at 0 in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else begin
      if (state == ST_INIT) clr_cnt <= clr_cnt + 1'b1;
      init_done <= (state_nxt == ST_RUN);
    end
  end

  assign arb_req = (state == ST_RUN) ? req_bus.req_valid : '0;
  assign granted = |grant;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (granted),
    .grant   (grant)
  );

  assign req_bus.req_ready = grant;

  // Payload of the granted requester (grant is one-hot, so OR-select)
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (grant[r]) begin
        sel_addr  = sel_addr  | req_bus.req_addr[BYTE_AW*r +: BYTE_AW];
        sel_wdata = sel_wdata | req_bus.req_wdata[8*r +: 8];
        sel_we    = sel_we    | req_bus.req_we[r];
      end
    end
  end

  assign sel_lane = sel_addr[1:0];

  // Output logic: macro drive per state
  always_comb begin
    ram_en = 1'b0;
    ram_a  = '0;
    ram_we = '0;
    ram_di = '0;
    case (state)
      ST_INIT: begin
        ram_en = 1'b1;
        ram_a  = clr_cnt;
        ram_we = '1;
      end
      ST_RUN: begin
        if (granted) begin
          ram_en = 1'b1;
          ram_a  = sel_addr[BYTE_AW-1:2];
          if (sel_we) begin
            ram_we = RAM_LANES'(1) << sel_lane;
            ram_di = 32'(sel_wdata) << {sel_lane, 3'b000};
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_lane_q  <= '0;
      rsp_read_q  <= 1'b0;
    end else begin
      rsp_valid_q <= grant;
      if (granted) begin
        rsp_lane_q <= sel_lane;
        rsp_read_q <= !sel_we;
      end
    end
  end

  assign req_bus.rsp_valid = rsp_valid_q;

  always_comb begin
    req_bus.rsp_rdata = 8'h00;
    if (|rsp_valid_q && rsp_read_q) req_bus.rsp_rdata = ram_do[{rsp_lane_q, 3'b000} +: 8];
  end

endmodule

// File: tb/tb_ram32_port_arbiter.sv
// Directed bench for ram32_port_arbiter with a behavioural RAM32 model.
module tb_ram32_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        init_done;
  logic        ram_en;
  logic [4:0]  ram_a;
  logic [3:0]  ram_we;
  logic [31:0] ram_di;
  logic [31:0] ram_do = '0;
  logic [31:0] mem [32] = '{default: 32'hFFFF_FFFF};

  int passed = 0;
  int total  = 0;

  ram32_port_arbiter_if #(.NUM_REQ(2)) bus ();

  ram32_port_arbiter #(
    .NUM_REQ        (2),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_bus   (bus),
    .init_done (init_done),
    .ram_en    (ram_en),
    .ram_a     (ram_a),
    .ram_we    (ram_we),
    .ram_di    (ram_di),
    .ram_do    (ram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM32 model: byte-enabled write, registered read on non-write cycles
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
      if (ram_we == 4'h0) ram_do <= mem[ram_a];
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int r, input logic we, input logic [6:0] a, input logic [7:0] d);
    bus.req_we[r]            = we;
    bus.req_addr[7*r +: 7]   = a;
    bus.req_wdata[8*r +: 8]  = d;
    bus.req_valid[r]         = 1'b1;
  endtask

  task automatic test_reset;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_rdata, init_done} !== 13'h0) begin
      $display("FAIL reset_outs: got ready=%b rsp_valid=%b rdata=%h done=%b required all 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_rdata, init_done);
    end else passed++;
    total++;
    if ({ram_en, ram_we, ram_a, ram_di} !== 42'h0) begin
      $display("FAIL reset_ram: got en=%b we=%h a=%0d di=%h required all 0", ram_en, ram_we, ram_a, ram_di);
    end else passed++;

    rst_n = 1'b1;
    drive(0, 1'b0, 7'h10, 8'h00);
    drive(1, 1'b0, 7'h20, 8'h00);
    tick();
    for (int k = 0; k < 32; k++) begin
      #1;
      total++;
      if ({ram_en, ram_we, ram_a, ram_di} !== {1'b1, 4'hF, 5'(k), 32'h0}) begin
        $display("FAIL init_clear[%0d]: got en=%b we=%h a=%0d di=%h required en=1 we=f a=%0d di=0",
                 k, ram_en, ram_we, ram_a, ram_di, k);
      end else passed++;
      total++;
      if ({bus.req_ready, init_done} !== 3'b000) begin
        $display("FAIL init_quiet[%0d]: got ready=%b done=%b required 00/0", k, bus.req_ready, init_done);
      end else passed++;
      if (k == 31) bus.req_valid = '0;
      tick();
    end
    total++;
    if ({init_done, ram_en} !== 2'b10) begin
      $display("FAIL init_done_edge33: got done=%b en=%b required done=1 en=0", init_done, ram_en);
    end else passed++;

    drive(0, 1'b0, 7'h45, 8'h00);
    #1;
    total++;
    if ({bus.req_ready, ram_en, ram_a, ram_we} !== {2'b01, 1'b1, 5'd17, 4'h0}) begin
      $display("FAIL read45_drive: got ready=%b en=%b a=%0d we=%h required 01/1/17/0",
               bus.req_ready, ram_en, ram_a, ram_we);
    end else passed++;
    tick();
    bus.req_valid = '0;
    total++;
    if ({bus.rsp_valid, bus.rsp_rdata} !== {2'b01, 8'h00}) begin
      $display("FAIL read45_rsp: got rsp_valid=%b rdata=%h required 01/00", bus.rsp_valid, bus.rsp_rdata);
    end else passed++;
    tick();
    total++;
    if ({bus.rsp_valid, bus.rsp_rdata} !== 10'h0) begin
      $display("FAIL idle_rsp: got rsp_valid=%b rdata=%h required 00/00", bus.rsp_valid, bus.rsp_rdata);
    end else passed++;
  endtask

  task automatic test_write_read;
    drive(0, 1'b1, 7'h13, 8'hA5);
    #1;
    total++;
    if ({bus.req_ready, ram_en, ram_a, ram_we, ram_di} !== {2'b01, 1'b1, 5'd4, 4'b1000, 32'hA500_0000}) begin
      $display("FAIL wr13_drive: got ready=%b en=%b a=%0d we=%b di=%h required 01/1/4/1000/a5000000",
               bus.req_ready, ram_en, ram_a, ram_we, ram_di);
    end else passed++;
    tick();
    drive(0, 1'b0, 7'h13, 8'h00);
    #1;
    total++;
    if ({bus.rsp_valid, bus.rsp_rdata, ram_we, ram_en} !== {2'b01, 8'h00, 4'h0, 1'b1}) begin
      $display("FAIL wr13_ack: got rsp_valid=%b rdata=%h we=%h en=%b required 01/00/0/1",
               bus.rsp_valid, bus.rsp_rdata, ram_we, ram_en);
    end else passed++;
    tick();
    bus.req_valid = '0;
    total++;
    if ({bus.rsp_valid, bus.rsp_rdata} !== {2'b01, 8'hA5}) begin
      $display("FAIL rd13_rsp: got rsp_valid=%b rdata=%h required 01/a5", bus.rsp_valid, bus.rsp_rdata);
    end else passed++;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [4];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'b1, 7'(i), bytes[i]);
      #1;
      total++;
      if ({bus.req_ready, ram_we, ram_di} !== {2'b10, 4'(1 << i), 32'(bytes[i]) << (8 * i)}) begin
        $display("FAIL b2b_wr[%0d]: got ready=%b we=%b di=%h", i, bus.req_ready, ram_we, ram_di);
      end else passed++;
      tick();
      total++;
      if (bus.rsp_valid !== 2'b10) begin
        $display("FAIL b2b_wr_ack[%0d]: got rsp_valid=%b required 10", i, bus.rsp_valid);
      end else passed++;
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 1'b0, 7'(i), 8'h00);
      #1;
      total++;
      if (bus.req_ready !== 2'b10) begin
        $display("FAIL b2b_rd_ready[%0d]: got %b required 10", i, bus.req_ready);
      end else passed++;
      tick();
      total++;
      if ({bus.rsp_valid, bus.rsp_rdata} !== {2'b10, bytes[i]}) begin
        $display("FAIL b2b_rd[%0d]: got rsp_valid=%b rdata=%h required 10/%h",
                 i, bus.rsp_valid, bus.rsp_rdata, bytes[i]);
      end else passed++;
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_alternate;
    logic [1:0] exp_rv;
    logic [7:0] exp_rd;
    drive(0, 1'b0, 7'h00, 8'h00);
    drive(1, 1'b0, 7'h03, 8'h00);
    for (int c = 0; c < 4; c++) begin
      #1;
      exp_rv = (c == 0) ? 2'b00 : ((c % 2) == 1) ? 2'b01 : 2'b10;
      exp_rd = (c == 0) ? 8'h00 : ((c % 2) == 1) ? 8'h11 : 8'h44;
      total++;
      if (bus.req_ready !== (((c % 2) == 0) ? 2'b01 : 2'b10)) begin
        $display("FAIL alt_grant[%0d]: got %b", c, bus.req_ready);
      end else passed++;
      total++;
      if ({bus.rsp_valid, bus.rsp_rdata} !== {exp_rv, exp_rd}) begin
        $display("FAIL alt_rsp[%0d]: got rsp_valid=%b rdata=%h required %b/%h",
                 c, bus.rsp_valid, bus.rsp_rdata, exp_rv, exp_rd);
      end else passed++;
      tick();
    end
    bus.req_valid = '0;
    total++;
    if ({bus.rsp_valid, bus.rsp_rdata} !== {2'b10, 8'h44}) begin
      $display("FAIL alt_last_rsp: got rsp_valid=%b rdata=%h required 10/44", bus.rsp_valid, bus.rsp_rdata);
    end else passed++;
    tick();
  endtask

  task automatic test_reset_mid;
    drive(0, 1'b0, 7'h13, 8'h00);
    tick();
    bus.req_valid = '0;
    total++;
    if ({bus.rsp_valid, bus.rsp_rdata} !== {2'b01, 8'hA5}) begin
      $display("FAIL pend_rsp: got rsp_valid=%b rdata=%h required 01/a5", bus.rsp_valid, bus.rsp_rdata);
    end else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.rsp_valid, bus.rsp_rdata, init_done} !== 11'h0) begin
      $display("FAIL rst_drop_rsp: got rsp_valid=%b rdata=%h done=%b required 0",
               bus.rsp_valid, bus.rsp_rdata, init_done);
    end else passed++;
    tick();
    rst_n = 1'b1;
    for (int e = 0; e < 18; e++) tick();
    #1;
    total++;
    if ({ram_a, ram_we} !== {5'd17, 4'hF}) begin
      $display("FAIL init_cnt17: got a=%0d we=%h required 17/f", ram_a, ram_we);
    end else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({ram_en, ram_a} !== 6'h0) begin
      $display("FAIL rst_mid_init: got en=%b a=%0d required 0/0", ram_en, ram_a);
    end else passed++;
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 33; e++) begin
      tick();
      if (e == 1) begin
        total++;
        if ({ram_en, ram_a, ram_we} !== {1'b1, 5'd0, 4'hF}) begin
          $display("FAIL init_restart: got en=%b a=%0d we=%h required 1/0/f", ram_en, ram_a, ram_we);
        end else passed++;
      end
      total++;
      if (init_done !== (e == 33)) begin
        $display("FAIL done_edge[%0d]: got %b required %b", e, init_done, (e == 33));
      end else passed++;
    end
    drive(0, 1'b0, 7'h13, 8'h00);
    drive(1, 1'b0, 7'h00, 8'h00);
    #1;
    total++;
    if (bus.req_ready !== 2'b01) begin
      $display("FAIL ptr_reset: got ready=%b required 01", bus.req_ready);
    end else passed++;
    tick();
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_max_addr;
    drive(0, 1'b1, 7'h7F, 8'h5A);
    #1;
    total++;
    if ({ram_a, ram_we, ram_di} !== {5'd31, 4'b1000, 32'h5A00_0000}) begin
      $display("FAIL wr7f_drive: got a=%0d we=%b di=%h required 31/1000/5a000000", ram_a, ram_we, ram_di);
    end else passed++;
    tick();
    drive(0, 1'b0, 7'h7F, 8'h00);
    #1;
    total++;
    if ({bus.rsp_valid, bus.rsp_rdata} !== {2'b01, 8'h00}) begin
      $display("FAIL wr7f_ack: got rsp_valid=%b rdata=%h required 01/00", bus.rsp_valid, bus.rsp_rdata);
    end else passed++;
    tick();
    bus.req_valid = '0;
    total++;
    if ({bus.rsp_valid, bus.rsp_rdata} !== {2'b01, 8'h5A}) begin
      $display("FAIL rd7f_rsp: got rsp_valid=%b rdata=%h required 01/5a", bus.rsp_valid, bus.rsp_rdata);
    end else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_alternate();
    test_reset_mid();
    test_max_addr();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
